// File: rtl/prog_loader.sv
// prog_loader: UART boot loader taking a big-endian byte-count header, then packing
// little-endian payload bytes into instruction-memory words, with an optional status byte.
module prog_loader #(
    parameter int WORD_BYTES = 4,
    parameter int SIZE_BYTES = 4,
    parameter int ADDR_W     = 12,
    parameter int ACK_EN     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [7:0]              tx_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int HW = 8 * SIZE_BYTES;
    localparam int DW = 8 * WORD_BYTES;
    localparam logic [63:0] MAX_N = 64'(WORD_BYTES) << ADDR_W;
    localparam logic [7:0] ST_OK = 8'hAA;
    localparam logic [7:0] ST_ERR = 8'hEE;

    typedef enum logic [2:0] {HDR, DATA, ACK, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     hdr_q, hdr_d, bcnt_q, bcnt_d, n_nxt;
    logic [7:0]        hcnt_q, hcnt_d, lane_q, lane_d, status_q, status_d;
    logic [DW-1:0]     pack_q, pack_d, wdata_q, wdata_d, word;
    logic [ADDR_W-1:0] widx_q, widx_d, addr_q, addr_d;
    logic              we_q, we_d, last_q, last_d, bad_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HDR;
            hdr_q    <= '0;
            bcnt_q   <= '0;
            hcnt_q   <= '0;
            lane_q   <= '0;
            status_q <= '0;
            pack_q   <= '0;
            wdata_q  <= '0;
            widx_q   <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            bcnt_q   <= bcnt_d;
            hcnt_q   <= hcnt_d;
            lane_q   <= lane_d;
            status_q <= status_d;
            pack_q   <= pack_d;
            wdata_q  <= wdata_d;
            widx_q   <= widx_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        bcnt_d   = bcnt_q;
        hcnt_d   = hcnt_q;
        lane_d   = lane_q;
        status_d = status_q;
        pack_d   = pack_q;
        wdata_d  = wdata_q;
        widx_d   = widx_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        last_d   = last_q;
        n_nxt    = (hdr_q << 8) | HW'(rx_data);
        bad_n    = ((n_nxt % HW'(WORD_BYTES)) != '0) || (64'(n_nxt) > MAX_N);
        word     = pack_q;
        word[DW-8 +: 8] = rx_data;
        case (state_q)
            HDR: if (rx_valid) begin
                hdr_d  = n_nxt;
                hcnt_d = hcnt_q + 8'd1;
                if (hcnt_q == 8'(SIZE_BYTES - 1)) begin
                    state_d  = (bad_n || n_nxt == '0) ? ACK : DATA;
                    status_d = bad_n ? ST_ERR : ST_OK;
                end
            end
            // last_q marks the final word's write cycle; leave only after it
            DATA: if (last_q) begin
                state_d  = ACK;
                status_d = ST_OK;
            end else if (rx_valid) begin
                bcnt_d = bcnt_q + 1'b1;
                if (lane_q == 8'(WORD_BYTES - 1)) begin
                    lane_d  = '0;
                    we_d    = 1'b1;
                    addr_d  = widx_q;
                    wdata_d = word;
                    widx_d  = widx_q + 1'b1;
                    last_d  = (bcnt_q + 1'b1) == hdr_q;
                end else begin
                    pack_d[8*lane_q +: 8] = rx_data;
                    lane_d = lane_q + 8'd1;
                end
            end
            ACK: if (ACK_EN == 0 || tx_ready) state_d = (status_q == ST_OK) ? DONE : ERR;
            default: ;
        endcase
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign tx_valid  = (state_q == ACK) && (ACK_EN != 0);
    assign tx_data   = status_q;
    assign busy      = (state_q == HDR && hcnt_q != '0) || state_q == DATA || state_q == ACK;
    assign done      = state_q == DONE;
    assign err       = state_q == ERR;
endmodule
